// File: rtl/vga_timing_out.sv
// vga_timing_out -- 640x480@60 VGA raster timing and output register stage.
//
// The pixel counters are visible on x_cnt/y_cnt so the draw blocks can
// return RGB combinationally. That RGB is registered on the same pix_en
// edge as hsync/vsync/blank_n, all decoded from the same (pre-increment)
// count. Every DAC-facing output therefore describes one pixel, with one
// pix_en of latency.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   pix_en               pixel strobe; all state advances only when high
//   x_cnt, y_cnt         current raster position (registers)
//   r_in, g_in, b_in     pixel colour from draw blocks (comb. in x/y_cnt)
//   vga_r/g/b            registered colour, forced to 0 outside active area
//   vga_hs, vga_vs       registered syncs, asserted level = SYNC_POL
//   vga_blank_n          registered, high for active pixels
//   vblank               comb. decode of y_cnt >= V_ACTIVE (game update window)
//   frame_tick           one-clk pulse after the edge that wraps to (0,0)
module vga_timing_out #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] x_cnt,
  output logic [9:0] y_cnt,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vblank,
  output logic       frame_tick
);

  // All region boundaries as 10-bit constants so every compare is 10 bits.
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic x_last, y_last, active, hs_on, vs_on;

  always_comb begin
    x_last = (x_cnt == H_LAST);
    y_last = (y_cnt == V_LAST);
    active = (x_cnt < H_ACT) && (y_cnt < V_ACT);
    hs_on  = (x_cnt >= HS_BEG) && (x_cnt <= HS_END);
    vs_on  = (y_cnt >= VS_BEG) && (y_cnt <= VS_END);
  end

  assign vblank = (y_cnt >= V_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_blank_n <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      // Re-evaluated every clk, so it can never stretch across a stall.
      frame_tick <= pix_en && x_last && y_last;
      if (pix_en) begin
        // Output stage uses the pre-increment count: same pixel the draw
        // blocks are currently looking at.
        vga_r       <= active ? r_in : 8'h00;
        vga_g       <= active ? g_in : 8'h00;
        vga_b       <= active ? b_in : 8'h00;
        vga_hs      <= hs_on ? SYNC_POL : ~SYNC_POL;
        vga_vs      <= vs_on ? SYNC_POL : ~SYNC_POL;
        vga_blank_n <= active;
        if (x_last) begin
          x_cnt <= '0;
          y_cnt <= y_last ? 10'd0 : y_cnt + 10'd1;
        end else begin
          x_cnt <= x_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Generates 640x480@60 VGA raster timing.
- Drives x_cnt/y_cnt to the sprite/card draw blocks, which return combinational RGB.
- Registers that RGB together with hsync, vsync and blank_n so all outputs stay cycle-aligned at the DAC.
- Also gives game logic a frame tick and a vblank flag, so sprite pin positions are updated only off-screen.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; counters and output registers advance only when high (1 in 2 at 50 MHz, tied high at 25 MHz)
- x_cnt  out  10  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800)
- y_cnt  out  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- r_in  in  8  pixel red from draw blocks, combinational in x_cnt/y_cnt
- g_in  in  8  pixel green from draw blocks
- b_in  in  8  pixel blue from draw blocks
- vga_r  out  8  registered red
- vga_g  out  8  registered green
- vga_b  out  8  registered blue
- vga_hs  out  1  registered hsync
- vga_vs  out  1  registered vsync
- vga_blank_n  out  1  registered; high during the active region
- vblank  out  1  high while y_cnt >= V_ACTIVE (unregistered decode of counter register)
- frame_tick  out  1  one-clk pulse at start of each frame

Behaviour:
- Counters
  - x_cnt/y_cnt are registers.
  - On clk with pix_en=1: x_cnt increments.
  - At x_cnt = H_TOTAL-1, x_cnt wraps to 0 and y_cnt increments.
  - At y_cnt = V_TOTAL-1 with x_cnt wrapping, y_cnt wraps to 0.
  - pix_en=0: all state holds.
- Region order per axis: active, front porch, sync, back porch.
  - Hsync asserted for x_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - Vsync asserted for y_cnt in 490..491.
  - Active = x_cnt < H_ACTIVE && y_cnt < V_ACTIVE.
- Output stage, 1 pix_en latency
  - On pix_en=1 the output registers capture: rgb = active ? {r_in, g_in, b_in} : 0; hs, vs and blank_n are decoded from the pre-increment x_cnt/y_cnt.
  - Result: outputs always describe the same pixel; no draw-block input needs its own delay.
  - Asserted sync drives the output to SYNC_POL; deasserted drives ~SYNC_POL.
- vblank: combinational from the y_cnt register; high for y_cnt 480..524.
- frame_tick
  - Registered.
  - High for exactly one clk cycle, in the cycle after the pix_en edge that moves (799,524) to (0,0).
  - Low in all other cycles, including stalls.
- Reset (asynchronous, any time including mid-line)
  - x_cnt = 0, y_cnt = 0.
  - vga_r/g/b = 0.
  - vga_hs = vga_vs = ~SYNC_POL.
  - vga_blank_n = 0, frame_tick = 0.
  - The first pix_en edge after release registers pixel (0,0).
  - No frame_tick is generated for the reset-induced restart.
- Width rules: compare counters at 10 bits; parameter sums must be ≤ 1023 (not checked in RTL).
- No other state; no FSM beyond the two counters.

Test Plan:
- Reset, pix_en=1, r_in=8'hFF, g_in=8'h00, b_in=8'h80 constant.
  - First edge: vga_r = FF, vga_b = 80, blank_n = 1.
  - Output at x=640 gives rgb = 0 and blank_n = 0.
- Hsync timing over one line: vga_hs low for exactly 96 enabled cycles, first falling edge registered from x_cnt = 656. Line period is 800 enabled cycles.
- Vsync and vblank over a full frame:
  - vga_vs low for exactly 1600 enabled cycles (lines 490–491).
  - vblank high for 45 lines.
  - frame_tick pulses once per 420000 enabled cycles.
- pix_en toggling 1/0 (50 MHz mode):
  - Counters advance on alternate clocks; outputs hold while pix_en = 0.
  - frame_tick stays one clk wide.
  - Frame period is 840000 clks.
- Asynchronous rst_n low mid-line at x_cnt = 300, y_cnt = 200:
  - Outputs go to reset values immediately, without a clock.
  - After release, counting restarts at (0,0) with no frame_tick.
- Draw-block alignment: r_in driven as (x_cnt == 10) ? FF : 0. vga_r = FF only in the output cycle following x_cnt = 10, on every active line and on no blanked line.
